// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the batch multiplier scheduler: state
// encoding, register map and STATUS word layout.
package mul_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_CHECK        = 4'd1,
    S_SET_BUSY     = 4'd2,
    S_RD_OP        = 4'd3,
    S_LATCH        = 4'd4,
    S_START        = 4'd5,
    S_WAIT_DONE    = 4'd6,
    S_WR_RES       = 4'd7,
    S_WR_STATUS    = 4'd8,
    S_ERR_STATUS   = 4'd9,
    S_WAIT_RELEASE = 4'd10,
    S_CLEAR        = 4'd11
  } state_e;

  localparam int CTRL_ADDR = 0;
  localparam int STAT_ADDR = 1;

  localparam int ST_DONE_BIT = 0;
  localparam int ST_BUSY_BIT = 1;
  localparam int ST_ERR_BIT  = 2;
  localparam int ST_CODE_LSB = 3;
  localparam int ST_CNT_LSB  = 8;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_COUNT   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic [31:0] status_word(input logic done, input logic bsy,
                                              input logic err, input logic [1:0] code,
                                              input logic [4:0] cnt);
    status_word = {19'h0, cnt, 3'b000, code, err, bsy, done};
  endfunction

endpackage

// File: rtl/mul_batch_scheduler_if.sv
// RAM FPGA-side port plus multiplier core handshake, bundled as one bus.
interface mul_batch_scheduler_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] ADDR;
  logic              WRITE_F;
  logic [31:0]       WRITE_DATA;
  logic [31:0]       READ_DATA;
  logic [3:0]        BYTE_ENABLE;
  logic [3:0]        mul_a;
  logic [3:0]        mul_b;
  logic              mul_start;
  logic              mul_done;
  logic [7:0]        mul_y;

  // Handshake: mul_start is a one-cycle request that qualifies mul_a/mul_b; mul_done
  // is a one-cycle response that qualifies mul_y and is only honoured while waiting.
  modport master (
    output ADDR, WRITE_F, WRITE_DATA, BYTE_ENABLE, mul_a, mul_b, mul_start,
    input  READ_DATA, mul_done, mul_y
  );

  modport slave (
    input  ADDR, WRITE_F, WRITE_DATA, BYTE_ENABLE, mul_a, mul_b, mul_start,
    output READ_DATA, mul_done, mul_y
  );
endinterface

// File: rtl/mul_sched_timer.sv
// Clearable, enabled cycle counter with a terminal-count flag at TIMEOUT-1.
module mul_sched_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == W'(TIMEOUT - 1));

  // Hold at terminal count instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)            cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mul_batch_scheduler.sv
// Walks a batch of operand pairs in shared RAM through the 4x4 multiplier,
// writing results and a final STATUS word, then waits for start to drop.
module mul_batch_scheduler
  import mul_sched_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                MAX_N     = 16,
  parameter logic [ADDR_W-1:0] OPND_BASE = 6'h10,
  parameter logic [ADDR_W-1:0] RES_BASE  = 6'h20,
  parameter int                TIMEOUT   = 1024
) (
  input  logic                   CLK,
  input  logic                   rst,
  mul_batch_scheduler_if.master  bus,
  output logic                   busy,
  output logic [3:0]             state_o
);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(CTRL_ADDR);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(STAT_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        a_q, a_d, b_q, b_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        n_q, n_d;
  logic              rd_valid_q;
  logic [1:0]        err_code;
  logic [4:0]        err_cnt;
  logic              tmr_tc;

  mul_sched_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK (CLK),
    .rst (rst),
    .clr (state_q == S_START),
    .en  (state_q == S_WAIT_DONE),
    .tc  (tmr_tc)
  );

  assign bus.ADDR        = addr_q;
  assign bus.WRITE_F     = wr_q;
  assign bus.WRITE_DATA  = wdata_q;
  assign bus.BYTE_ENABLE = 4'b1111;
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;
  assign bus.mul_start   = start_q;
  assign busy            = busy_q;
  assign state_o         = state_q;

  // Next state, index and operand latching.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    err_code = ERR_NONE;
    err_cnt  = '0;
    case (state_q)
      S_IDLE: if (rd_valid_q && bus.READ_DATA[0]) begin
        n_d     = bus.READ_DATA[12:8];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (n_q == 5'd0 || 32'(n_q) > MAX_N) begin
          err_code = ERR_COUNT;
          state_d  = S_ERR_STATUS;
        end else begin
          state_d = S_SET_BUSY;
        end
      end
      S_SET_BUSY: begin
        idx_d   = '0;
        state_d = S_RD_OP;
      end
      S_RD_OP: state_d = S_LATCH;
      S_LATCH: begin
        a_d     = bus.READ_DATA[3:0];
        b_d     = bus.READ_DATA[7:4];
        state_d = S_START;
      end
      S_START: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.mul_done) begin
          state_d = S_WR_RES;
        end else if (tmr_tc) begin
          err_code = ERR_TIMEOUT;
          err_cnt  = idx_q;
          state_d  = S_ERR_STATUS;
        end
      end
      S_WR_RES: begin
        if (idx_q == n_q - 5'd1) begin
          state_d = S_WR_STATUS;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_RD_OP;
        end
      end
      S_WR_STATUS, S_ERR_STATUS: state_d = S_WAIT_RELEASE;
      S_WAIT_RELEASE: if (rd_valid_q && !bus.READ_DATA[0]) state_d = S_CLEAR;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they register in step with it.
  always_comb begin
    addr_d  = A_CTRL;
    wr_d    = 1'b0;
    wdata_d = '0;
    start_d = 1'b0;
    busy_d  = (state_d inside {S_CHECK, S_SET_BUSY, S_RD_OP, S_LATCH, S_START,
                               S_WAIT_DONE, S_WR_RES, S_WR_STATUS, S_ERR_STATUS});
    case (state_d)
      S_SET_BUSY: begin
        addr_d  = A_STAT;
        wr_d    = 1'b1;
        wdata_d = status_word(1'b0, 1'b1, 1'b0, ERR_NONE, 5'd0);
      end
      S_RD_OP, S_LATCH: addr_d = OPND_BASE + ADDR_W'(idx_d);
      S_START: start_d = 1'b1;
      S_WR_RES: begin
        addr_d  = RES_BASE + ADDR_W'(idx_q);
        wr_d    = 1'b1;
        wdata_d = {24'h0, bus.mul_y};
      end
      S_WR_STATUS: begin
        addr_d  = A_STAT;
        wr_d    = 1'b1;
        wdata_d = status_word(1'b1, 1'b0, 1'b0, ERR_NONE, n_q);
      end
      S_ERR_STATUS: begin
        addr_d  = A_STAT;
        wr_d    = 1'b1;
        wdata_d = status_word(1'b0, 1'b0, 1'b1, err_code, err_cnt);
      end
      S_CLEAR: begin
        addr_d = A_STAT;
        wr_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= A_CTRL;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      idx_q      <= '0;
      n_q        <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      a_q        <= a_d;
      b_q        <= b_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      // READ_DATA reflects CONTROL only after ADDR held CONTROL on a read cycle.
      rd_valid_q <= (addr_q == A_CTRL) && !wr_q;
    end
  end
endmodule
